// File: rtl/alu_seq_if.sv
// Instruction/result bundle for alu_seq: master issues instructions, slave (the ALU) answers.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [3+2*WIDTH-1:0] instr;
  logic                 start;
  logic [WIDTH-1:0]     result1;
  logic [WIDTH-1:0]     result2;
  logic                 carry;
  logic                 overflow;
  logic                 busy;
  logic                 done;

  modport master (
    output instr, start,
    input  result1, result2, carry, overflow, busy, done
  );

  modport slave (
    input  instr, start,
    output result1, result2, carry, overflow, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/compare, iterative shift-add MUL and
// restoring DIV. The divider is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic             ovf;
    logic             cry;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] r1;
  } res_t;

  function automatic res_t fast_op(input logic [2:0] op,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    res_t                    r;
    logic [WIDTH:0]          ext;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    r   = '0;
    ext = '0;
    sa  = a;
    sb  = b;
    case (op)
      3'b000: begin
        ext   = {1'b0, a} + {1'b0, b};
        r.r1  = ext[WIDTH-1:0];
        r.cry = ext[WIDTH];
        r.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        // Borrow shows up as the wrapped MSB of the extended difference.
        ext   = {1'b0, a} - {1'b0, b};
        r.r1  = ext[WIDTH-1:0];
        r.cry = ext[WIDTH];
        r.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: r.r1 = a & b;
      3'b011: r.r1 = a | b;
      3'b100: r.r1 = a ^ b;
      3'b101: r.r1 = {{(WIDTH-3){1'b0}}, (sa < sb), (a < b), (a == b)};
      default: r.ovf = 1'b1;
    endcase
    return r;
  endfunction

  logic [2:0]       op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             iter;
  res_t             fast_res;

  assign op_in    = bus.instr[3+2*WIDTH-1:2*WIDTH];
  assign a_in     = bus.instr[2*WIDTH-1:WIDTH];
  assign b_in     = bus.instr[WIDTH-1:0];
  assign fast_res = fast_op(op_in, a_in, b_in);
`ifdef ALU_SEQ_DIV_EN
  assign iter = (op_in[2:1] == 2'b11);
`else
  assign iter = (op_in == 3'b110);
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH:0]   psum;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] r2_q;
  logic             cry_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             last_ovf;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] b_q;
  logic             is_div_q;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
`endif

  // One iteration step: MUL shifts {hi,lo} right after adding a; DIV shifts the
  // partial remainder left and subtracts b whenever it fits.
  always_comb begin
    hi_nx    = hi_q;
    lo_nx    = lo_q;
    psum     = '0;
    last_ovf = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, b_q});
    if (is_div_q) begin
      hi_nx    = ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
      lo_nx    = {lo_q[WIDTH-2:0], ge};
      last_ovf = (b_q == '0);
    end else
`endif
    begin
      psum           = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      {hi_nx, lo_nx} = {psum, lo_q[WIDTH-1:1]};
      last_ovf       = (hi_nx != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      cry_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      b_q      <= '0;
      is_div_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (iter) begin
              state <= RUN;
              cnt   <= '0;
              a_q   <= a_in;
              hi_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
              b_q      <= b_in;
              is_div_q <= op_in[0];
              lo_q     <= op_in[0] ? a_in : b_in;
`else
              lo_q     <= b_in;
`endif
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
              r1_q   <= fast_res.r1;
              r2_q   <= fast_res.r2;
              cry_q  <= fast_res.cry;
              ovf_q  <= fast_res.ovf;
            end
          end
        end
        RUN: begin
          hi_q <= hi_nx;
          lo_q <= lo_nx;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            state  <= DONE;
            done_q <= 1'b1;
            r1_q   <= lo_nx;
            r2_q   <= hi_nx;
            cry_q  <= 1'b0;
            ovf_q  <= last_ovf;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result1  = r1_q;
  assign bus.result2  = r2_q;
  assign bus.carry    = cry_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq (WIDTH=8); expected results come from plain arithmetic.
module tb_alu_seq;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         c;
    logic         o;
    int           lat;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sb, s, p;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    e.r1 = '0; e.r2 = '0; e.c = 1'b0; e.o = 1'b0; e.lat = 0; e.cyc = 0;
    case (op)
      3'd0: begin
        s = ua + ub; e.r1 = W'(s); e.c = (s > 255);
        s = sa + sb; e.o = (s > 127) || (s < -128);
      end
      3'd1: begin
        s = ua - ub; e.r1 = W'(s); e.c = (ua < ub);
        s = sa - sb; e.o = (s > 127) || (s < -128);
      end
      3'd2: e.r1 = a & b;
      3'd3: e.r1 = a | b;
      3'd4: e.r1 = a ^ b;
      3'd5: e.r1 = W'((sa < sb) * 4 + (ua < ub) * 2 + (ua == ub));
      3'd6: begin
        p = ua * ub; e.r1 = W'(p); e.r2 = W'(p / 256); e.o = (p > 255); e.lat = W;
      end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        e.lat = W;
        if (ub == 0) begin
          e.r1 = 8'hFF; e.r2 = a; e.o = 1'b1;
        end else begin
          e.r1 = W'(ua / ub); e.r2 = W'(ua % ub);
        end
`else
        e.o = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result1", bus.result1, e.r1);
        check("result2", bus.result2, e.r2);
        check("carry", bus.carry, e.c);
        check("overflow", bus.overflow, e.o);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (bus.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 1, 0);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    bus.instr = {op, a, b};
    bus.start = 1'b1;
    e = model(op, a, b);
    e.cyc = cyc + 1 + e.lat;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.instr = (3+2*W)'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result1"}, bus.result1, 0);
    check({tag, "_result2"}, bus.result2, 0);
    check({tag, "_carry"}, bus.carry, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    int   nbusy;
    int   guard;
    exp_t e;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.instr = '0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner vectors
    issue(3'd0, 8'hFF, 8'h01);
    issue(3'd1, 8'h80, 8'h01);
    issue(3'd5, 8'h80, 8'h01);
    issue(3'd5, 8'h33, 8'h33);
    issue(3'd6, 8'hFF, 8'hFF);
    nbusy = 1;
    guard = 0;
    while (bus.busy && guard < 50) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      guard++;
    end
    check("mul_busy_cycles", nbusy, W + 1);
    issue(3'd7, 8'h64, 8'h07);
    issue(3'd7, 8'h2A, 8'h00);
    issue(3'd6, 8'h00, 8'h5A);

    // start held high with instr churning during a MUL; next accept only after DONE.
    wait_idle();
    bus.instr = {3'd6, 8'h0D, 8'h0B};
    bus.start = 1'b1;
    e = model(3'd6, 8'h0D, 8'h0B);
    e.cyc = cyc + 1 + e.lat;
    exp_q.push_back(e);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (!bus.done) bus.instr = (3+2*W)'($urandom);
    end while (!bus.done && guard < 50);
    if (guard >= 50) check("hold_timeout", 1, 0);
    bus.instr = {3'd0, 8'h12, 8'h34};
    e = model(3'd0, 8'h12, 8'h34);
    e.cyc = cyc + 2;
    exp_q.push_back(e);
    repeat (2) @(negedge clk);
    bus.start = 1'b0;

    // Reset in the middle of a MUL: no done, everything cleared at once.
    wait_idle();
    bus.instr = {3'd6, 8'hC3, 8'h7E};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 8'h03, 8'h04);

    // Randomized traffic, biased toward zero and all-ones operands.
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) a = '1;
      issue(op, a, b);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("pending_expectations", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  3+2*WIDTH  {op[2:0], a[WIDTH-1:0], b[WIDTH-1:0]}, op in MSBs.
REQ-005 SHALL have port start  input  1  request to accept instr.
REQ-006 SHALL have port result1  output  WIDTH  primary result (sum/difference/logic/compare, MUL low half, DIV quotient).
REQ-007 SHALL have port result2  output  WIDTH  secondary result (MUL high half, DIV remainder, else 0).
REQ-008 SHALL have port carry  output  1  carry/borrow flag.
REQ-009 SHALL have port overflow  output  1  overflow/error flag.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress or completing.
REQ-011 SHALL have port done  output  1  one-cycle pulse; results valid and stable from this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; busy = (state != IDLE).
REQ-013 SHALL accept an instruction only at a rising edge where state = IDLE and start = 1, latching op, a, b; start in RUN or DONE SHALL be ignored.
REQ-014 SHALL, for ops 000-101, compute and register results at the accept edge and go IDLE->DONE (done high the following cycle).
REQ-015 SHALL, for ops 110/111, go IDLE->RUN, iterate one bit per cycle for exactly WIDTH cycles, register results on the last RUN edge, then enter DONE.
REQ-016 SHALL go DONE->IDLE unconditionally after one cycle; done high only in DONE.
REQ-017 SHALL hold result1, result2, carry, overflow unchanged from DONE until the next accepted operation's result edge; changes on instr during RUN SHALL have no effect.
REQ-018 ADD (000): result1 = a+b mod 2^WIDTH; carry = unsigned carry-out; overflow = two's-complement signed overflow.
REQ-019 SUB (001): result1 = a-b mod 2^WIDTH; carry = borrow (a < b unsigned); overflow = signed overflow.
REQ-020 AND/OR/XOR (010/011/100): bitwise result1; result2, carry, overflow = 0.
REQ-021 CMP (101): result1[0] = (a==b), [1] = (a<b unsigned), [2] = (a<b signed), other bits 0; carry, overflow = 0.
REQ-022 MUL (110): unsigned shift-add; {result2,result1} = a*b (2*WIDTH bits); overflow = (result2 != 0); carry = 0.
REQ-023 DIV (111): unsigned restoring division; result1 = a/b, result2 = a%b; carry, overflow = 0.
REQ-024 DIV with b = 0: result1 = all ones, result2 = a, overflow = 1, still WIDTH RUN cycles.

Reset
REQ-025 SHALL, while rst_n = 0, force state IDLE and result1, result2, carry, overflow, busy, done to 0, independent of clk.
REQ-026 SHALL abandon any in-flight MUL/DIV on reset with no done pulse; first accept possible at first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile the iterative divider only when macro ALU_SEQ_DIV_EN is defined; with it, op 111 behaves per REQ-023/024.
REQ-028 SHALL, without ALU_SEQ_DIV_EN, treat op 111 as single-cycle illegal op: result1 = result2 = 0, carry = 0, overflow = 1, done one cycle after accept; no divider logic present.

Verification (WIDTH=8, ALU_SEQ_DIV_EN defined unless stated)
REQ-029 ADD a=0xFF b=0x01 -> result1 0x00, carry 1, overflow 0, done in cycle after accept edge; SUB a=0x80 b=0x01 -> 0x7F, carry 0, overflow 1.
REQ-030 MUL a=0xFF b=0xFF -> result1 0x01, result2 0xFE, overflow 1, done exactly 9 cycles after accept edge, busy high 9 cycles.
REQ-031 DIV a=0x64 b=0x07 -> result1 0x0E, result2 0x02, overflow 0; DIV a=0x2A b=0x00 -> result1 0xFF, result2 0x2A, overflow 1.
REQ-032 start held high and instr toggled throughout a MUL -> only first instr accepted, results per first operands, next accept no earlier than cycle after done.
REQ-033 rst_n pulsed low mid-MUL (RUN cycle 4) -> all outputs 0 immediately, no done; subsequent ADD 0x03+0x04 -> 0x07.
REQ-034 ALU_SEQ_DIV_EN undefined, DIV a=0x64 b=0x07 -> result1 0x00, result2 0x00, overflow 1, done in cycle after accept edge.
